// File: rtl/risc_pkg.sv
// Shared register-file constants for the integer pipeline.
package risc_pkg;

    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;
    localparam int REG_COUNT = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr, first request wins.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [PW-1:0] idx;

    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter onto the register file's single write port, with a
// pending-write scoreboard that stalls issue on write-after-write hazards.
module regfile_wb_arbiter
    import risc_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = REG_DW,
    parameter int AW   = REG_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [AW-1:0]        wta,
    output logic [DW-1:0]        wtd,
    output logic                 cnt,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_addr,
    output logic                 issue_ready,
    output logic [REG_COUNT-1:0] pending
);

    localparam int PW = $clog2(NREQ);

    logic [PW-1:0]        ptr;
    logic [PW-1:0]        gnt_idx;
    logic                 xfer;
    logic [AW-1:0]        addr_arr [NREQ];
    logic [DW-1:0]        data_arr [NREQ];
    logic [AW-1:0]        win_addr;
    logic [DW-1:0]        win_data;
    logic [REG_COUNT-1:0] pending_nxt;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_arr[i] = req_addr[i*AW +: AW];
        assign data_arr[i] = req_data[i*DW +: DW];
    end

    // Grant depends only on req_valid and ptr; the winner's payload is muxed afterwards.
    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx),
        .any     (xfer)
    );

    assign win_addr    = addr_arr[gnt_idx];
    assign win_data    = data_arr[gnt_idx];
    assign issue_ready = (issue_addr == '0) || !pending[issue_addr];

    // Clear first, then set, so a new writer dispatched this cycle stays tracked.
    always_comb begin
        pending_nxt = pending;
        if (xfer && win_addr != '0)
            pending_nxt[win_addr] = 1'b0;
        if (issue_valid && issue_ready && issue_addr != '0)
            pending_nxt[issue_addr] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking '<=' and every register here has an async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= PW'(NREQ - 1);
            wta     <= '0;
            wtd     <= '0;
            cnt     <= 1'b0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            if (xfer) begin
                ptr <= gnt_idx;
                wta <= win_addr;
                wtd <= win_data;
                cnt <= (win_addr != '0);
            end else begin
                cnt <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter against a behavioural model, plus directed scenarios.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [AW-1:0]     wta;
    logic [DW-1:0]     wtd;
    logic              cnt;
    logic              issue_valid;
    logic [AW-1:0]     issue_addr;
    logic              issue_ready;
    logic [31:0]       pending;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .wta         (wta),
        .wtd         (wtd),
        .cnt         (cnt),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .pending     (pending)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Reference model: architectural state only, updated from the written rules.
    int          m_ptr;
    logic [AW-1:0] m_wta;
    logic [DW-1:0] m_wtd;
    logic        m_cnt;
    logic [31:0] m_pend;
    int          n_ptr;
    logic [AW-1:0] n_wta;
    logic [DW-1:0] n_wtd;
    logic        n_cnt;
    logic [31:0] n_pend;
    bit          chk_en = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  <= NREQ - 1;
            m_wta  <= '0;
            m_wtd  <= '0;
            m_cnt  <= 1'b0;
            m_pend <= '0;
        end else if (chk_en) begin
            m_ptr  <= n_ptr;
            m_wta  <= n_wta;
            m_wtd  <= n_wtd;
            m_cnt  <= n_cnt;
            m_pend <= n_pend;
        end
    end

    always @(negedge clk) begin : cmp
        int best, bestd, d;
        logic [NREQ-1:0] e_rdy;
        logic e_iready;
        logic [AW-1:0] a;
        if (chk_en) begin
            best  = -1;
            bestd = NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i]) begin
                    d = (i - m_ptr - 1 + 2 * NREQ) % NREQ;
                    if (d < bestd) begin
                        bestd = d;
                        best  = i;
                    end
                end
            end
            e_rdy = '0;
            if (best >= 0) e_rdy[best] = 1'b1;
            e_iready = (issue_addr == 0) || (m_pend[issue_addr] == 1'b0);

            check("req_ready", 64'(req_ready), 64'(e_rdy));
            check("issue_ready", 64'(issue_ready), 64'(e_iready));
            check("cnt", 64'(cnt), 64'(m_cnt));
            check("wta", 64'(wta), 64'(m_wta));
            check("wtd", 64'(wtd), 64'(m_wtd));
            check("pending", 64'(pending), 64'(m_pend));

            n_ptr  = m_ptr;
            n_wta  = m_wta;
            n_wtd  = m_wtd;
            n_cnt  = 1'b0;
            n_pend = m_pend;
            if (best >= 0) begin
                a      = req_addr[best*AW +: AW];
                n_ptr  = best;
                n_wta  = a;
                n_wtd  = req_data[best*DW +: DW];
                n_cnt  = (a != 0);
                if (a != 0) n_pend[a] = 1'b0;
            end
            if (issue_valid && e_iready && issue_addr != 0) n_pend[issue_addr] = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rr;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;

        // Reset values, then a single write from requester 1.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_cnt", 64'(cnt), 64'd0);
        check("rst_wta", 64'(wta), 64'd0);
        check("rst_wtd", 64'(wtd), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_req(1, 1'b1, 5'd3, 32'hA5);
        @(negedge clk);
        check("t1_grant", 64'(req_ready), 64'b010);
        @(posedge clk);
        #1 set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        check("t1_cnt", 64'(cnt), 64'd1);
        check("t1_wta", 64'(wta), 64'd3);
        check("t1_wtd", 64'(wtd), 64'hA5);

        // Round-robin with all requesters continuously valid.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(4 + i), DW'(32'h100 + i));
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_grant", 64'(req_ready), 64'(1 << (k % 3)));
            if (k > 0) begin
                check("rr_cnt", 64'(cnt), 64'd1);
                check("rr_wta", 64'(wta), 64'(4 + ((k - 1) % 3)));
            end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);

        // Write to r0: handshake completes, no register write, pointer moves to 0.
        do_reset();
        set_req(0, 1'b1, 5'd0, 32'hFF);
        @(negedge clk);
        check("r0_grant", 64'(req_ready), 64'b001);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(1 + i), DW'(i));
        @(negedge clk);
        check("r0_cnt", 64'(cnt), 64'd0);
        check("r0_next_grant", 64'(req_ready), 64'b010);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);

        // Scoreboard set, stall, clear by writeback.
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        @(negedge clk);
        check("sb_ready0", 64'(issue_ready), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sb_set", 64'(pending[7]), 64'd1);
        check("sb_stall", 64'(issue_ready), 64'd0);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        set_req(2, 1'b1, 5'd7, 32'h77);
        @(negedge clk);
        check("sb_grant2", 64'(req_ready), 64'b100);
        @(posedge clk);
        #1 set_req(2, 1'b0, '0, '0);
        @(negedge clk);
        check("sb_clear", 64'(pending[7]), 64'd0);
        check("sb_ready1", 64'(issue_ready), 64'd1);
        check("sb_wta", 64'(wta), 64'd7);

        // Set and clear of r9 in the same cycle: set wins.
        @(posedge clk);
        #1 issue_valid = 1'b1;
        issue_addr = 5'd9;
        set_req(0, 1'b1, 5'd9, 32'h99);
        @(negedge clk);
        check("col_grant", 64'(req_ready), 64'b001);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        set_req(0, 1'b0, '0, '0);
        @(negedge clk);
        check("col_pending9", 64'(pending[9]), 64'd1);
        check("col_cnt", 64'(cnt), 64'd1);
        check("col_wta", 64'(wta), 64'd9);

        // Asynchronous reset between edges with writes in flight.
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        @(posedge clk);
        #1 issue_addr = 5'd11;
        set_req(1, 1'b1, 5'd3, 32'h33);
        @(posedge clk);
        #1 issue_valid = 1'b0;
        set_req(1, 1'b0, '0, '0);
        @(negedge clk);
        check("ar_pending", 64'(pending), 64'h880);
        check("ar_cnt", 64'(cnt), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_cnt0", 64'(cnt), 64'd0);
        check("ar_wta0", 64'(wta), 64'd0);
        check("ar_wtd0", 64'(wtd), 64'd0);
        check("ar_pending0", 64'(pending), 64'd0);
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(1 + i), DW'(i));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("ar_first_grant", 64'(req_ready), 64'b001);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, '0, '0);

        // Randomized traffic; requesters hold their request until accepted.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            rr = rst_n ? req_ready : '0;
            @(posedge clk);
            #1;
            if (!rst_n) rst_n = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || rr[i]) begin
                    if ($urandom_range(0, 3) != 0)
                        set_req(i, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom));
                    else
                        set_req(i, 1'b0, '0, '0);
                end
            end
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = AW'($urandom_range(0, 15));
            if (n % 700 == 350) #3 rst_n = 1'b0;
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32-bit register file's single write port. Up to NREQ execution units (ALU, load unit, multiplier) request register writes; the block grants one per cycle round-robin, registers the winner onto the register file's write port (`wta`/`wtd`/`cnt`), and tracks in-flight destination registers so the issue stage can stall on write-after-write hazards.

## Interface
- `NREQ`, 3, number of write-back requesters (2..8)
- `DW`, 32, data width
- `AW`, 5, register address width (32 registers, r0 hard-wired zero)

- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `req_valid`  in  NREQ  requester i has a write pending
- `req_addr`  in  NREQ*AW  destination of requester i, slice [i*AW +: AW]
- `req_data`  in  NREQ*DW  write data of requester i, slice [i*DW +: DW]
- `req_ready`  out  NREQ  one-hot grant; transfer when `req_valid[i] && req_ready[i]`
- `wta`  out  AW  register file write address
- `wtd`  out  DW  register file write data
- `cnt`  out  1  register file write enable
- `issue_valid`  in  1  issue stage dispatching an instruction that writes `issue_addr`
- `issue_addr`  in  AW  destination of the dispatching instruction
- `issue_ready`  out  1  destination free; dispatch accepted when `issue_valid && issue_ready`
- `pending`  out  32  per-register in-flight bitmap, bit 0 always 0

## Operation
- Arbitration: combinational round-robin over `req_valid`, search starts at `ptr+1 mod NREQ`; first valid index wins, `req_ready` one-hot on winner, all zero if no valid.
- `req_ready` depends only on `req_valid` and `ptr`, never on `req_addr`/`req_data`.
- On a transfer: `ptr` <= winner; output register loads `wta`=addr, `wtd`=data, `cnt`=1 if addr≠0 else 0.
- No transfer: `cnt`<=0; `wta`/`wtd` hold previous values.
- Writes to r0: accepted (handshake completes, pointer advances) but `cnt`=0; register never written.
- Scoreboard set: accepted dispatch with `issue_addr`≠0 sets `pending[issue_addr]`.
- Scoreboard clear: transfer with addr≠0 clears `pending[addr]` at the accepting edge.
- Same register set and cleared in one cycle: set wins (new writer in flight).
- `issue_ready` = (`issue_addr`==0) or !`pending[issue_addr]`; no bypass of a same-cycle clear.
- Requester writing a register not pending: written normally; scoreboard unchanged (no error flag).
- Requesters hold `req_valid`/`req_addr`/`req_data` stable until accepted.

## Timing
- Reset values: `ptr`=NREQ-1 (requester 0 highest priority first), `wta`=0, `wtd`=0, `cnt`=0, `pending`=0; `req_ready`/`issue_ready` follow combinationally from reset state.
- Reset asserted mid-operation: outputs clear immediately; a write presented on `cnt` that cycle is lost; in-flight requesters re-request after reset.
- Latency: accepted in cycle N -> `cnt` high during N+1 -> register file updated at the rising edge ending N+1.
- Throughput: one write per cycle; back-to-back grants to different requesters with no bubble.
- Fairness: a continuously valid requester is granted within NREQ cycles.
- `pending` cleared at accept edge N, one cycle before the register file write; readers rely on the register file's write-through forwarding during N+1.

## Structure
- Shared package `risc_pkg`: `REG_AW`=5, `REG_DW`=32, `REG_COUNT`=32, `REG_ZERO`=5'd0.
- Sub-module `rr_arbiter` (parameter N; inputs `req`, `ptr`; output one-hot `gnt`, encoded `gnt_idx`, `any`): purely combinational, reusable for memory-port arbitration.
- Top holds `ptr`, output register and scoreboard.

## Test plan
- Reset: `rst_n`=0 -> `cnt`=0, `wta`=0, `wtd`=0, `pending`=0; release, single `req_valid[1]` addr 3 data 0xA5 -> `req_ready`=3'b010, next cycle `cnt`=1, `wta`=3, `wtd`=0xA5.
- Round-robin: all three valid continuously with addrs 4,5,6 -> grants 0,1,2,0,1,2; `cnt` high every cycle after first.
- r0 write: requester 0 addr 0 data 0xFF -> `req_ready[0]`=1, next cycle `cnt`=0, `ptr`=0.
- Scoreboard: dispatch addr 7 -> `pending[7]`=1; second dispatch addr 7 -> `issue_ready`=0; requester 2 writes addr 7 -> `pending[7]`=0 next cycle, `issue_ready`=1.
- Set/clear collision: dispatch addr 9 in the same cycle requester 0 writeback to 9 accepted -> `pending[9]` stays 1, `cnt`=1 `wta`=9 next cycle.
- Async reset mid-stream: drop `rst_n` between edges with `pending`=0x0000_0880 and `cnt`=1 -> all outputs zero immediately; after release, requester 0 granted first.
